// File: rtl/stream_sync_pkg.sv
// Shared types and default constants for the stream_drive_sync block.
package stream_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_FREE     = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_SERVICE_CYCLES = 4;
  localparam int unsigned DEF_FREE_WIDTH     = 3;
  localparam int unsigned DEF_CNT_W          = 16;

  // Width of the shared BUSY/FREE down-counter (service time up to 255).
  localparam int unsigned TMR_W = 8;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage deeper each clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer chain register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/stream_drive_sync.sv
// Request sink for a 2-way mutex merge: synchronizes i_drive, accepts one
// request per rising edge, holds BUSY for SERVICE_CYCLES, then pulses o_free
// for FREE_WIDTH cycles and waits for the request to drop.
// Optional overrun detection is compiled in with STREAM_DRIVE_SYNC_OVF_EN.
module stream_drive_sync
  import stream_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned SERVICE_CYCLES = DEF_SERVICE_CYCLES,
  parameter int unsigned FREE_WIDTH     = DEF_FREE_WIDTH,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_drive,
  output logic             o_free,
  output logic             o_start,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_evt_cnt,
  input  logic             i_clr_ovf,
  output logic             o_overrun
);

  logic             drive_sync;
  logic             prev_q, prev_d;
  logic             rise;
  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             free_q, free_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst),
    .d    (i_drive),
    .q    (drive_sync)
  );

  // Edge detection, next-state logic and registered output decode.
  always_comb begin
    prev_d    = drive_sync;
    rise      = drive_sync & ~prev_q;
    state_d   = state_q;
    tmr_d     = tmr_q;
    start_d   = 1'b0;
    evt_cnt_d = evt_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d   = ST_BUSY;
          tmr_d     = TMR_W'(SERVICE_CYCLES - 1);
          start_d   = 1'b1;
          evt_cnt_d = evt_cnt_q + CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (tmr_q == '0) begin
          state_d = ST_FREE;
          tmr_d   = TMR_W'(FREE_WIDTH - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_FREE: begin
        if (tmr_q == '0) begin
          // If the request already dropped during FREE, the low phase has
          // been seen and WAIT_LOW would only cost a cycle; skipping it keeps
          // minimum-spaced requests from landing on a non-IDLE state.
          state_d = drive_sync ? ST_WAIT_LOW : ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_WAIT_LOW: begin
        if (!drive_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_BUSY);
    free_d = (state_d == ST_FREE);
  end

  // Control and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q    <= 1'b0;
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      free_q    <= 1'b0;
      evt_cnt_q <= '0;
    end else begin
      prev_q    <= prev_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      free_q    <= free_d;
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign o_start   = start_q;
  assign o_busy    = busy_q;
  assign o_free    = free_q;
  assign o_evt_cnt = evt_cnt_q;

`ifdef STREAM_DRIVE_SYNC_OVF_EN
  logic overrun_q, overrun_d;

  // Sticky overrun: an edge outside IDLE sets it; set beats clear.
  always_comb begin
    overrun_d = overrun_q;
    if (i_clr_ovf) overrun_d = 1'b0;
    if (rise && (state_q != ST_IDLE)) overrun_d = 1'b1;
  end

  // Overrun flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overrun_q <= 1'b0;
    else      overrun_q <= overrun_d;
  end

  assign o_overrun = overrun_q;
`else
  logic unused_clr_ovf;
  assign unused_clr_ovf = i_clr_ovf;
  assign o_overrun      = 1'b0;
`endif

endmodule

// File: tb/tb_stream_drive_sync.sv
// Directed bench for stream_drive_sync: default instance, a 4-bit counter
// instance and a fast-service instance, checked against hand-derived cycles.
module tb_stream_drive_sync;

`ifdef STREAM_DRIVE_SYNC_OVF_EN
  localparam int EXP_OVF = 1;
`else
  localparam int EXP_OVF = 0;
`endif

  logic clk;
  int   n_checks = 0;
  int   n_errors = 0;

  // Default instance
  logic        a_rst, a_drv, a_clr, a_free, a_start, a_busy, a_ovf;
  logic [15:0] a_evt;
  // CNT_W = 4 instance
  logic        w_rst, w_drv, w_clr, w_free, w_start, w_busy, w_ovf;
  logic [3:0]  w_evt;
  // SERVICE_CYCLES = 1, FREE_WIDTH = 2 instance
  logic        f_rst, f_drv, f_clr, f_free, f_start, f_busy, f_ovf;
  logic [15:0] f_evt;

  stream_drive_sync dut_a (
    .clk(clk), .rst(a_rst), .i_drive(a_drv), .o_free(a_free), .o_start(a_start),
    .o_busy(a_busy), .o_evt_cnt(a_evt), .i_clr_ovf(a_clr), .o_overrun(a_ovf)
  );

  stream_drive_sync #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(w_rst), .i_drive(w_drv), .o_free(w_free), .o_start(w_start),
    .o_busy(w_busy), .o_evt_cnt(w_evt), .i_clr_ovf(w_clr), .o_overrun(w_ovf)
  );

  stream_drive_sync #(.SERVICE_CYCLES(1), .FREE_WIDTH(2)) dut_f (
    .clk(clk), .rst(f_rst), .i_drive(f_drv), .o_free(f_free), .o_start(f_start),
    .o_busy(f_busy), .o_evt_cnt(f_evt), .i_clr_ovf(f_clr), .o_overrun(f_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int st_n, st_first, bz_n, fr_n, fr_first, ovl, ovf_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_pat(input int lo, input int hi);
    logic [127:0] p;
    p = '0;
    for (int i = lo; i <= hi; i++) p[i] = 1'b1;
    return p;
  endfunction

  // Drive a_drv from pat (bit c applies to the posedge after negedge c) and
  // tally outputs of the default instance at each negedge.
  task automatic run_a(input int n, input logic [127:0] pat);
    st_n = 0; st_first = 0; bz_n = 0; fr_n = 0; fr_first = 0; ovl = 0; ovf_seen = 0;
    a_drv = pat[0];
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (a_start) begin st_n++; if (st_first == 0) st_first = c; end
      if (a_busy) bz_n++;
      if (a_free) begin fr_n++; if (fr_first == 0) fr_first = c; end
      if (a_busy && a_free) ovl++;
      if (a_ovf) ovf_seen = 1;
      a_drv = pat[c];
    end
  endtask

  task automatic tally_f();
    @(negedge clk);
    if (f_start) st_n++;
    if (f_busy) bz_n++;
    if (f_free) fr_n++;
    if (f_busy && f_free) ovl++;
    if (f_ovf) ovf_seen = 1;
  endtask

  initial begin
    a_rst = 1'b0; a_drv = 1'b0; a_clr = 1'b0;
    w_rst = 1'b0; w_drv = 1'b0; w_clr = 1'b0;
    f_rst = 1'b0; f_drv = 1'b0; f_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_start", 32'(a_start), 0);
    check("rst_busy",  32'(a_busy),  0);
    check("rst_free",  32'(a_free),  0);
    check("rst_evt",   32'(a_evt),   0);
    check("rst_ovf",   32'(a_ovf),   0);
    a_rst = 1'b1; w_rst = 1'b1; f_rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single 6-cycle pulse
    run_a(20, mk_pat(0, 5));
    check("p6_starts",    32'(st_n),     1);
    check("p6_start_at",  32'(st_first), 3);
    check("p6_busy_cyc",  32'(bz_n),     4);
    check("p6_free_cyc",  32'(fr_n),     3);
    check("p6_free_at",   32'(fr_first), 7);
    check("p6_overlap",   32'(ovl),      0);
    check("p6_evt",       32'(a_evt),    1);
    check("p6_ovf",       32'(a_ovf),    0);

    // Held high 40 cycles: exactly one request
    run_a(50, mk_pat(0, 39));
    check("h40_starts",   32'(st_n),  1);
    check("h40_busy_cyc", 32'(bz_n),  4);
    check("h40_free_cyc", 32'(fr_n),  3);
    check("h40_evt",      32'(a_evt), 2);

    // Held high into WAIT_LOW, then exactly 2 low cycles, then high again
    run_a(20, mk_pat(0, 20));
    check("wl_starts", 32'(st_n),     1);
    check("wl_at",     32'(st_first), 3);
    run_a(30, mk_pat(2, 29));
    check("low2_starts",   32'(st_n),     1);
    check("low2_start_at", 32'(st_first), 5);
    check("low2_evt",      32'(a_evt),    4);
    run_a(10, '0);

    // Second edge while BUSY
    run_a(20, mk_pat(0, 1) | mk_pat(4, 5));
    check("ovr_starts",   32'(st_n),  1);
    check("ovr_busy_cyc", 32'(bz_n),  4);
    check("ovr_evt",      32'(a_evt), 5);
    check("ovr_flag",     32'(a_ovf), 32'(EXP_OVF));
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    check("ovr_cleared", 32'(a_ovf), 0);
    // Clear held high: the set cycle must still show the flag
    a_clr = 1'b1;
    run_a(20, mk_pat(0, 1) | mk_pat(4, 5));
    check("ovr_set_wins",  32'(ovf_seen), 32'(EXP_OVF));
    check("ovr_clr_final", 32'(a_ovf),    0);
    check("ovr2_evt",      32'(a_evt),    6);
    a_clr = 1'b0;

    // Reset in the second BUSY cycle with i_drive held high
    run_a(4, mk_pat(0, 4));
    check("rb_start_at", 32'(st_first), 3);
    check("rb_busy_cyc", 32'(bz_n),     2);
    a_rst = 1'b0;
    #1;
    check("rb_busy_now", 32'(a_busy), 0);
    check("rb_evt_now",  32'(a_evt),  0);
    check("rb_free_now", 32'(a_free), 0);
    repeat (2) @(negedge clk);
    check("rb_free_hold", 32'(a_free), 0);
    a_rst = 1'b1;
    run_a(20, mk_pat(0, 20));
    check("rb_new_starts",   32'(st_n),     1);
    check("rb_new_start_at", 32'(st_first), 3);
    check("rb_new_free_cyc", 32'(fr_n),     3);
    check("rb_new_evt",      32'(a_evt),    1);
    run_a(10, '0);

    // CNT_W = 4 wrap over 17 requests
    for (int i = 0; i < 17; i++) begin
      w_drv = 1'b1;
      repeat (4) @(negedge clk);
      w_drv = 1'b0;
      repeat (12) @(negedge clk);
      check($sformatf("wrap_evt%0d", i), 32'(w_evt), 32'((i + 1) % 16));
    end
    check("wrap_final", 32'(w_evt), 1);
    check("wrap_ovf",   32'(w_ovf), 0);

    // Minimum-spaced requests on the fast instance
    st_n = 0; bz_n = 0; fr_n = 0; ovl = 0; ovf_seen = 0;
    for (int p = 0; p < 8; p++) begin
      f_drv = 1'b1;
      repeat (2) tally_f();
      f_drv = 1'b0;
      repeat (2) tally_f();
    end
    repeat (12) tally_f();
    check("fast_starts",   32'(st_n),     8);
    check("fast_busy_cyc", 32'(bz_n),     8);
    check("fast_free_cyc", 32'(fr_n),     16);
    check("fast_overlap",  32'(ovl),      0);
    check("fast_evt",      32'(f_evt),    8);
    check("fast_ovf",      32'(ovf_seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_drive_sync.md
STREAM_DRIVE_SYNC -- requirements
Module: stream_drive_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on i_drive (legal 2..4).
REQ-002 Parameter SERVICE_CYCLES, default 4, clock cycles spent in BUSY per accepted request (legal 1..255).
REQ-003 Parameter FREE_WIDTH, default 3, clock cycles o_free is held high (legal 2..15).
REQ-004 Parameter CNT_W, default 16, width of o_evt_cnt.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; asynchronous assert, active-low (0 = reset), synchronous deassert by integrator.
REQ-007 i_drive  input  1  request from upstream 2-way mutex merge (its o_driveNext); asynchronous to clk.
REQ-008 o_free  output  1  release back to merge (its i_freeNext); registered.
REQ-009 o_start  output  1  one-cycle pulse when a request is accepted; registered.
REQ-010 o_busy  output  1  high while FSM is in BUSY.
REQ-011 o_evt_cnt  output  CNT_W  count of accepted requests.
REQ-012 i_clr_ovf  input  1  synchronous clear of o_overrun.
REQ-013 o_overrun  output  1  sticky overrun flag.

Function
REQ-014 i_drive SHALL pass through SYNC_STAGES flops before any use; one further flop SHALL hold the previous synced value for rising-edge detection.
REQ-015 Upstream contract: i_drive high >= 2 clk periods and low >= 2 clk periods between requests; narrower pulses are undefined.
REQ-016 FSM states: IDLE, BUSY, FREE, WAIT_LOW.
REQ-017 IDLE -> BUSY on detected synced rising edge; same edge SHALL assert o_start for exactly one cycle and increment o_evt_cnt.
REQ-018 BUSY SHALL last exactly SERVICE_CYCLES cycles (down-counter), then -> FREE.
REQ-019 FREE SHALL hold o_free high for exactly FREE_WIDTH cycles, then -> WAIT_LOW.
REQ-020 WAIT_LOW -> IDLE in the first cycle synced i_drive is 0; a rising edge detected in that same cycle SHALL NOT be accepted.
REQ-021 Latency: i_drive rise sampled at clk edge k -> o_start high in cycle k+SYNC_STAGES+1; o_free rises SERVICE_CYCLES cycles after o_start rises.
REQ-022 o_evt_cnt SHALL wrap from 2^CNT_W-1 to 0 without flagging.
REQ-023 Rising edges detected outside IDLE SHALL be ignored (no count, no o_start).
REQ-024 o_free SHALL never be high outside FREE; o_busy and o_free SHALL never be high together.

Reset
REQ-025 rst low SHALL immediately force: FSM IDLE, synchronizer and edge flops 0, counters 0, o_free 0, o_start 0, o_busy 0, o_evt_cnt 0, o_overrun 0.
REQ-026 Reset mid-BUSY or mid-FREE SHALL abort the request without emitting o_free; if i_drive is still high after release, its 0->1 sync transition SHALL be treated as a new request.

Configuration
REQ-027 Macro STREAM_DRIVE_SYNC_OVF_EN compiled in: a synced rising edge detected in BUSY, FREE or WAIT_LOW SHALL set o_overrun; i_clr_ovf=1 clears it next cycle; set wins over clear in the same cycle.
REQ-028 Macro absent: o_overrun SHALL be constant 0, i_clr_ovf unused, no overrun logic synthesized; ports remain present.

Structure
REQ-029 Package stream_sync_pkg SHALL hold the FSM state typedef (2-bit enum) and default parameter constants.
REQ-030 Synchronizer SHALL be a separate sub-module sync_ff (parameter STAGES, async active-low reset), instantiated once.

Verification
REQ-031 Defaults, one i_drive pulse 6 clk wide -> o_start once at sample+3, o_busy 4 cycles, o_free 3 cycles, o_evt_cnt=1.
REQ-032 i_drive held high 40 cycles -> exactly one request; next request accepted only after i_drive low >= 2 cycles.
REQ-033 Second rising edge during BUSY with OVF_EN -> no o_start, o_evt_cnt unchanged, o_overrun=1; i_clr_ovf pulse -> 0; without macro o_overrun stays 0.
REQ-034 CNT_W=4, 17 spaced requests -> o_evt_cnt sequence wraps 15->0, final value 1.
REQ-035 rst pulled low in cycle 2 of BUSY -> all outputs 0 at once, no o_free; i_drive held high through release -> one new o_start after sync.
REQ-036 SERVICE_CYCLES=1, FREE_WIDTH=2, back-to-back minimum-spaced requests -> each gets exactly 1 BUSY and 2 o_free cycles, none lost or duplicated.
